seven_seg_scan_ctrl: RTL and testbench
======================================

# seven_seg_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. Holds a 16-bit hex value and walks the digits one at a time, each followed by a blanking gap. For the current digit it presents the 4-bit nibble to the existing hex-to-segment decoder, drives the active-low anode, and drives the decimal point. New values are double-buffered and committed only at frame boundaries, so a digit is never shown from a half-updated value.

## Interface
- `DEAD_CYC`, default 2000: blanking (all anodes off) cycles before each digit; must be ≥1.
- `SHOW_CYC`, default 48000: cycles each digit is lit; must be ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `load`  in  1  single-cycle strobe; captures `value` and `dp_in` into the shadow registers.
- `value`  in  16  four hex digits; digit *i* = `value[4i+3:4i]`, digit 3 is leftmost.
- `dp_in`  in  4  decimal-point enables, one bit per digit, 1 = lit.
- `blank_lz`  in  1  1 = suppress leading zeros. Sampled live, not buffered.
- `nibble`  out  4  hex digit for the current digit; wired to the decoder's data input.
- `an`  out  4  active-low anode enables; at most one bit low at any time.
- `dp_n`  out  1  active-low decimal point for the current digit.
- `frame_done`  out  1  one-cycle pulse at the end of digit 3's SHOW phase.
- `pending`  out  1  1 = the shadow holds a load that is not yet committed.

## Operation
- Registers:
  - `disp` (16), `disp_dp` (4): the committed value being displayed.
  - `shadow` (16), `shadow_dp` (4): the most recent load.
  - `idx` (2): current digit.
  - `state`: BLANK or SHOW.
  - `cnt`: phase counter, width ⌈log2(max(DEAD_CYC,SHOW_CYC))⌉.
- BLANK:
  - `an`=4'b1111.
  - The counter runs 0..DEAD_CYC-1. When `cnt`=DEAD_CYC-1: `cnt`←0, go to SHOW.
- SHOW:
  - `nibble`=`disp[4·idx+:4]`.
  - `dp_n`=~`disp_dp[idx]`.
  - `an` has bit `idx` low unless that digit is suppressed.
  - The counter runs 0..SHOW_CYC-1. When `cnt`=SHOW_CYC-1: `cnt`←0, go to BLANK.
  - If `idx`<3, `idx`←`idx`+1.
  - If `idx`=3 (frame end): `idx`←0 and `frame_done`=1 for that cycle.
  - Also at frame end: if `pending`, then `disp`←`shadow`, `disp_dp`←`shadow_dp`, `pending`←0.
- Load: `load`=1 → `shadow`←`value`, `shadow_dp`←`dp_in`, `pending`←1. Back-to-back loads overwrite; the last one wins.
- Load in the same cycle as a frame-end commit: `disp`/`disp_dp` take `value`/`dp_in` directly. `shadow` is also updated, and `pending`←0.
- Leading-zero suppression:
  - With `blank_lz`=1, digit *i* ∈ {3,2,1} keeps its anode high during SHOW if `disp` nibbles 3..*i* are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit also forces `dp_n`=1.
  - The digit's time slot is still consumed, so frame timing is unchanged.
- The decoder's bit 7 (decimal point) is ignored by the top level; `dp_n` drives the DP pin.

## Timing
- `nibble`, `an`, `dp_n` and `frame_done` are registered. They change on the same edge as the state transition, so the anode and its data always switch together.
- Per-digit period: DEAD_CYC+SHOW_CYC cycles. Frame: 4·(DEAD_CYC+SHOW_CYC) cycles.
- Commit latency after `load`: from 1 cycle (load on the frame-end cycle, applied directly) up to one full frame.
- Reset values:
  - `state`=BLANK, `cnt`=0, `idx`=0.
  - `an`=4'b1111, `nibble`=0, `dp_n`=1, `frame_done`=0, `pending`=0.
  - `disp`, `shadow`, `disp_dp`, `shadow_dp` all 0.
- Reset during SHOW: on the next cycle `an`=4'b1111 and scanning restarts from BLANK, digit 0. Any uncommitted load is discarded.
- First lit digit after reset release: digit 0 at cycle DEAD_CYC, showing 0.
- `load` asserted during `rst` is ignored.

## Test plan
- Reset: hold `rst` for 3 cycles with `load`=1, `value`=16'hFFFF, then release. Required:
  - `an`=1111 and `pending`=0 throughout.
  - With DEAD=2, `an`=1110 and `nibble`=0 from cycle 2.
- Scan order: DEAD=2, SHOW=4, load 16'h1234 and wait one frame. Required:
  - `an` sequence 1110/1101/1011/0111 with `nibble` 4,3,2,1.
  - Each digit lit 4 cycles, with 2 blank cycles before each.
  - `frame_done` high exactly once per 24 cycles.
- Mid-frame load: while digit 1 is lit, load 16'hABCD. Required:
  - Digits 2 and 3 still show the old value.
  - `pending`=1 until frame end.
  - The next frame shows D,C,B,A.
- Coincident load: assert `load` with 16'h5A5A exactly on the `frame_done` cycle while `pending`=1 holding 16'h1111. Required: the next frame shows 16'h5A5A and `pending`=0.
- Leading zeros: `blank_lz`=1, value 16'h0042, `dp_in`=4'b1000. Required:
  - Digits 3 and 2 keep `an`=1111 with `dp_n`=1.
  - Digits 1 and 0 show 4 and 2.
  - Value 16'h0000 lights only digit 0.
- Reset mid-operation: assert `rst` during digit 2's SHOW with `pending`=1. Required:
  - The next cycle has `an`=1111, `pending`=0 and `idx`=0.
  - Display restarts showing 0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// Walks digits 0..3, each preceded by a blanking gap. The displayed value
// is double-buffered and only committed at the end of a frame.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_BLANK | all anodes off for DEAD_CYC cycles before the next digit
// ST_SHOW  | digit idx lit for SHOW_CYC cycles (unless zero-suppressed)
//
// DEAD_CYC and SHOW_CYC must both be at least 1.
module seven_seg_scan_ctrl #(
    parameter int DEAD_CYC = 2000,
    parameter int SHOW_CYC = 48000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        frame_done,
    output logic        pending
);

    localparam int MAX_CYC = (DEAD_CYC > SHOW_CYC) ? DEAD_CYC : SHOW_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYC - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     disp_q, disp_d;
    logic [3:0]      disp_dp_q, disp_dp_d;
    logic [15:0]     shadow_q, shadow_d;
    logic [3:0]      shadow_dp_q, shadow_dp_d;
    logic            pending_q, pending_d;
    logic [3:0]      nibble_q, nibble_d;
    logic [3:0]      an_q, an_d;
    logic            dp_n_q, dp_n_d;
    logic            frame_done_q, frame_done_d;
    logic            frame_end;

    // A digit above digit 0 is hidden when it and every digit to its left are zero.
    function automatic logic lz_hide(input logic [15:0] v, input logic [1:0] i);
        case (i)
            2'd3:    lz_hide = (v[15:12] == 4'h0);
            2'd2:    lz_hide = (v[15:8] == 8'h0);
            2'd1:    lz_hide = (v[15:4] == 12'h0);
            default: lz_hide = 1'b0;
        endcase
    endfunction

    // Next-state: phase sequencing, load capture, frame-end commit, and the
    // output values, computed from the next state so they switch with it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        disp_d       = disp_q;
        disp_dp_d    = disp_dp_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        frame_end    = 1'b0;
        nibble_d     = 4'h0;
        an_d         = 4'b1111;
        dp_n_d       = 1'b1;
        frame_done_d = 1'b0;

        if (state_q == ST_BLANK) begin
            if (cnt_q == DEAD_LAST) begin
                cnt_d   = '0;
                state_d = ST_SHOW;
            end
        end else begin
            if (cnt_q == SHOW_LAST) begin
                cnt_d     = '0;
                state_d   = ST_BLANK;
                frame_end = (idx_q == 2'd3);
                idx_d     = idx_q + 2'd1;
            end
        end

        if (load) begin
            shadow_d    = value;
            shadow_dp_d = dp_in;
            pending_d   = 1'b1;
        end

        // A load landing on the commit cycle bypasses the shadow.
        if (frame_end) begin
            if (load) begin
                disp_d    = value;
                disp_dp_d = dp_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                disp_d    = shadow_q;
                disp_dp_d = shadow_dp_q;
                pending_d = 1'b0;
            end
        end

        nibble_d = disp_d[{idx_d, 2'b00} +: 4];
        if (state_d == ST_SHOW && !(blank_lz && lz_hide(disp_d, idx_d))) begin
            an_d[idx_d] = 1'b0;
            dp_n_d      = ~disp_dp_d[idx_d];
        end
        // High during the last SHOW cycle of digit 3, i.e. the commit cycle.
        frame_done_d = (state_d == ST_SHOW) && (idx_d == 2'd3) && (cnt_d == SHOW_LAST);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'h0;
            disp_dp_q    <= 4'h0;
            shadow_q     <= 16'h0;
            shadow_dp_q  <= 4'h0;
            pending_q    <= 1'b0;
            nibble_q     <= 4'h0;
            an_q         <= 4'b1111;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            nibble_q     <= nibble_d;
            an_q         <= an_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign nibble     = nibble_q;
    assign an         = an_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with DEAD_CYC=2, SHOW_CYC=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_seven_seg_scan_ctrl;

    localparam int DEAD = 2;
    localparam int SHOW = 4;
    localparam int SLOT = DEAD + SHOW;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp_n;
    logic        frame_done;
    logic        pending;

    int checks = 0;
    int errors = 0;

    // Load scheduled inside the next slot: step index (-1 = none), value, dp.
    int          ld_step = -1;
    logic [15:0] ld_val  = 16'h0;
    logic [3:0]  ld_dp   = 4'h0;

    seven_seg_scan_ctrl #(.DEAD_CYC(DEAD), .SHOW_CYC(SHOW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .nibble     (nibble),
        .an         (an),
        .dp_n       (dp_n),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One digit slot, starting on the sample point where the blank phase begins.
    task automatic slot(input logic [3:0] ea, input logic [3:0] en, input logic edn,
                        input logic last, input int nsteps);
        for (int s = 0; s < nsteps; s++) begin
            if (s < DEAD) begin
                chk("blank_an", 16'(an), 16'hF);
                chk("blank_dpn", 16'(dp_n), 16'h1);
                chk("blank_fd", 16'(frame_done), 16'h0);
            end else begin
                chk("show_an", 16'(an), 16'(ea));
                chk("show_nib", 16'(nibble), 16'(en));
                chk("show_dpn", 16'(dp_n), 16'(edn));
                chk("show_fd", 16'(frame_done), 16'(last && (s == SLOT - 1)));
            end
            load = (s == ld_step);
            if (s == ld_step) begin
                value = ld_val;
                dp_in = ld_dp;
            end
            @(negedge clk);
        end
        load    = 1'b0;
        ld_step = -1;
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b1;
        value    = 16'hFFFF;
        dp_in    = 4'hF;
        blank_lz = 1'b0;

        // Reset held 3 cycles with a load that must be ignored.
        repeat (3) begin
            @(negedge clk);
            chk("rst_an", 16'(an), 16'hF);
            chk("rst_pending", 16'(pending), 16'h0);
            chk("rst_fd", 16'(frame_done), 16'h0);
        end
        rst   = 1'b0;
        load  = 1'b0;
        value = 16'h0;
        dp_in = 4'h0;

        // Frame 0: displays 0000; load 1234 early.
        ld_step = 0; ld_val = 16'h1234; ld_dp = 4'h0;
        slot(4'hE, 4'h0, 1'b1, 1'b0, SLOT);
        chk("f0_pending", 16'(pending), 16'h1);
        slot(4'hD, 4'h0, 1'b1, 1'b0, SLOT);
        slot(4'hB, 4'h0, 1'b1, 1'b0, SLOT);
        slot(4'h7, 4'h0, 1'b1, 1'b1, SLOT);
        chk("f0_commit_pending", 16'(pending), 16'h0);

        // Frame 1: 1234; load ABCD while digit 1 is lit.
        slot(4'hE, 4'h4, 1'b1, 1'b0, SLOT);
        ld_step = DEAD + 1; ld_val = 16'hABCD; ld_dp = 4'h0;
        slot(4'hD, 4'h3, 1'b1, 1'b0, SLOT);
        chk("f1_pending", 16'(pending), 16'h1);
        slot(4'hB, 4'h2, 1'b1, 1'b0, SLOT);
        chk("f1_pending_late", 16'(pending), 16'h1);
        slot(4'h7, 4'h1, 1'b1, 1'b1, SLOT);
        chk("f1_commit_pending", 16'(pending), 16'h0);

        // Frame 2: ABCD; pend 1111, then load 5A5A on the frame_done cycle.
        ld_step = 0; ld_val = 16'h1111; ld_dp = 4'h0;
        slot(4'hE, 4'hD, 1'b1, 1'b0, SLOT);
        slot(4'hD, 4'hC, 1'b1, 1'b0, SLOT);
        slot(4'hB, 4'hB, 1'b1, 1'b0, SLOT);
        chk("f2_pending", 16'(pending), 16'h1);
        ld_step = SLOT - 1; ld_val = 16'h5A5A; ld_dp = 4'b0101;
        slot(4'h7, 4'hA, 1'b1, 1'b1, SLOT);
        chk("f2_coincident_pending", 16'(pending), 16'h0);

        // Frame 3: 5A5A with DPs on digits 0 and 2; enable zero suppression.
        blank_lz = 1'b1;
        ld_step = 0; ld_val = 16'h0042; ld_dp = 4'b1000;
        slot(4'hE, 4'hA, 1'b0, 1'b0, SLOT);
        slot(4'hD, 4'h5, 1'b1, 1'b0, SLOT);
        slot(4'hB, 4'hA, 1'b0, 1'b0, SLOT);
        slot(4'h7, 4'h5, 1'b1, 1'b1, SLOT);

        // Frame 4: 0042, digits 3 and 2 suppressed (DP on digit 3 forced off).
        ld_step = 0; ld_val = 16'h0000; ld_dp = 4'h0;
        slot(4'hE, 4'h2, 1'b1, 1'b0, SLOT);
        slot(4'hD, 4'h4, 1'b1, 1'b0, SLOT);
        slot(4'hF, 4'h0, 1'b1, 1'b0, SLOT);
        slot(4'hF, 4'h0, 1'b1, 1'b1, SLOT);

        // Frame 5: 0000, only digit 0 lit.
        slot(4'hE, 4'h0, 1'b1, 1'b0, SLOT);
        slot(4'hF, 4'h0, 1'b1, 1'b0, SLOT);
        slot(4'hF, 4'h0, 1'b1, 1'b0, SLOT);
        slot(4'hF, 4'h0, 1'b1, 1'b1, SLOT);

        // Frame 6: suppression off; pend 9876 then reset inside digit 2's SHOW.
        blank_lz = 1'b0;
        ld_step = 0; ld_val = 16'h9876; ld_dp = 4'hF;
        slot(4'hE, 4'h0, 1'b1, 1'b0, SLOT);
        slot(4'hD, 4'h0, 1'b1, 1'b0, SLOT);
        slot(4'hB, 4'h0, 1'b1, 1'b0, DEAD + 2);
        chk("pre_rst_pending", 16'(pending), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_an", 16'(an), 16'hF);
        chk("midrst_pending", 16'(pending), 16'h0);
        chk("midrst_dpn", 16'(dp_n), 16'h1);
        rst = 1'b0;

        // Frame 7: restart from digit 0, pending load discarded, shows 0000.
        slot(4'hE, 4'h0, 1'b1, 1'b0, SLOT);
        slot(4'hD, 4'h0, 1'b1, 1'b0, SLOT);
        slot(4'hB, 4'h0, 1'b1, 1'b0, SLOT);
        slot(4'h7, 4'h0, 1'b1, 1'b1, SLOT);
        chk("f7_pending", 16'(pending), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
